// File: rtl/iq_stream_join_if.sv
// iq_stream_join_if: I and Q input streams plus the paired I/Q output stream.
interface iq_stream_join_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_i_tdata;
  logic             in_i_tvalid;
  logic             in_i_tready;
  logic [WIDTH-1:0] in_q_tdata;
  logic             in_q_tvalid;
  logic             in_q_tready;
  logic [WIDTH-1:0] out_i_tdata;
  logic [WIDTH-1:0] out_q_tdata;
  logic             out_tvalid;
  logic             out_tready;
  modport master (
    output in_i_tdata, in_i_tvalid, in_q_tdata, in_q_tvalid, out_tready,
    input  in_i_tready, in_q_tready, out_i_tdata, out_q_tdata, out_tvalid
  );
  modport slave (
    input  in_i_tdata, in_i_tvalid, in_q_tdata, in_q_tvalid, out_tready,
    output in_i_tready, in_q_tready, out_i_tdata, out_q_tdata, out_tvalid
  );
endinterface

// File: rtl/iq_stream_join.sv
// iq_stream_join: pairs independent I and Q streams into one I/Q beat stream.
// Each channel has a one-entry holding register; a beat is valid once both are held.
module iq_stream_join #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  iq_stream_join_if.slave s
);
  logic [WIDTH-1:0] r_i_data;
  logic [WIDTH-1:0] r_q_data;
  logic             r_i_valid;
  logic             r_q_valid;
  logic             w_out_valid;
  logic             w_out_xfer;
  logic             w_i_ready;
  logic             w_q_ready;
  logic             w_i_load;
  logic             w_q_load;
  assign w_out_valid = r_i_valid & r_q_valid;
  assign w_out_xfer  = w_out_valid & s.out_tready;
  // Ready looks through the output transfer so a consumed entry refills in the same cycle.
  assign w_i_ready   = ~r_i_valid | w_out_xfer;
  assign w_q_ready   = ~r_q_valid | w_out_xfer;
  assign w_i_load    = s.in_i_tvalid & w_i_ready;
  assign w_q_load    = s.in_q_tvalid & w_q_ready;
  assign s.in_i_tready = w_i_ready;
  assign s.in_q_tready = w_q_ready;
  assign s.out_tvalid  = w_out_valid;
  assign s.out_i_tdata = r_i_data;
  assign s.out_q_tdata = r_q_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_data  <= '0;
      r_i_valid <= 1'b0;
    end else begin
      if (w_i_load) r_i_data <= s.in_i_tdata;
      r_i_valid <= w_i_load ? 1'b1 : (w_out_xfer ? 1'b0 : r_i_valid);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_data  <= '0;
      r_q_valid <= 1'b0;
    end else begin
      if (w_q_load) r_q_data <= s.in_q_tdata;
      r_q_valid <= w_q_load ? 1'b1 : (w_out_xfer ? 1'b0 : r_q_valid);
    end
  end
endmodule

// File: tb/tb_iq_stream_join.sv
// tb_iq_stream_join: directed vector table plus a streaming sequence for iq_stream_join.
module tb_iq_stream_join;
  typedef struct {
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic [15:0] q_data;
    logic        q_valid;
    logic        o_ready;
    logic        e_i_ready;
    logic        e_q_ready;
    logic        e_o_valid;
    logic [15:0] e_o_i;
    logic [15:0] e_o_q;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int beats;
  vec_t v[23];
  iq_stream_join_if #(.WIDTH(16)) bus ();
  iq_stream_join #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [15:0] id, input logic iv,
                       input logic [15:0] qd, input logic qv, input logic ordy);
    @(negedge clk);
    rst_n = r;
    bus.in_i_tdata  = id;
    bus.in_i_tvalid = iv;
    bus.in_q_tdata  = qd;
    bus.in_q_tvalid = qv;
    bus.out_tready  = ordy;
    #1;
  endtask
  function automatic vec_t mk(input logic r, input logic [15:0] id, input logic iv,
                              input logic [15:0] qd, input logic qv, input logic ordy,
                              input logic eir, input logic eqr, input logic eov,
                              input logic [15:0] eoi, input logic [15:0] eoq);
    vec_t t;
    t = '{r, id, iv, qd, qv, ordy, eir, eqr, eov, eoi, eoq};
    return t;
  endfunction
  initial begin
    bus.in_i_tdata = '0; bus.in_i_tvalid = 0;
    bus.in_q_tdata = '0; bus.in_q_tvalid = 0;
    bus.out_tready = 0;
    v[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 16'h0000);
    v[1]  = mk(1, 16'h1234, 1, 16'h5678, 1, 1, 1, 1, 0, 16'h0000, 16'h0000);
    v[2]  = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h1234, 16'h5678);
    v[3]  = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 0, 16'h1234, 16'h5678);
    v[4]  = mk(1, 16'h0001, 1, 16'h0000, 0, 1, 1, 1, 0, 16'h1234, 16'h5678);
    v[5]  = mk(1, 16'h00AA, 1, 16'h0000, 0, 1, 0, 1, 0, 16'h0001, 16'h5678);
    v[6]  = mk(1, 16'h00AA, 1, 16'h0000, 0, 1, 0, 1, 0, 16'h0001, 16'h5678);
    v[7]  = mk(1, 16'h00AA, 1, 16'h0002, 1, 1, 0, 1, 0, 16'h0001, 16'h5678);
    v[8]  = mk(1, 16'h00AA, 1, 16'h0000, 0, 1, 1, 1, 1, 16'h0001, 16'h0002);
    v[9]  = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h00AA, 16'h0002);
    v[10] = mk(1, 16'h0000, 0, 16'h0BBB, 1, 0, 0, 1, 0, 16'h00AA, 16'h0002);
    v[11] = mk(1, 16'h0CCC, 1, 16'h0DDD, 1, 0, 0, 0, 1, 16'h00AA, 16'h0BBB);
    v[12] = mk(1, 16'h0CCC, 1, 16'h0DDD, 1, 0, 0, 0, 1, 16'h00AA, 16'h0BBB);
    v[13] = mk(1, 16'h0CCC, 1, 16'h0DDD, 1, 1, 1, 1, 1, 16'h00AA, 16'h0BBB);
    v[14] = mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0CCC, 16'h0DDD);
    v[15] = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h0CCC, 16'h0DDD);
    v[16] = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 0, 16'h0CCC, 16'h0DDD);
    v[17] = mk(1, 16'h0EEE, 1, 16'h0000, 0, 1, 1, 1, 0, 16'h0CCC, 16'h0DDD);
    v[18] = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0, 16'h0EEE, 16'h0DDD);
    v[19] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 16'h0000);
    v[20] = mk(1, 16'h0000, 0, 16'h0FFF, 1, 1, 1, 1, 0, 16'h0000, 16'h0000);
    v[21] = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0FFF);
    v[22] = mk(1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0FFF);
    for (int k = 0; k < 23; k++) begin
      drive(v[k].rst_n, v[k].i_data, v[k].i_valid, v[k].q_data, v[k].q_valid, v[k].o_ready);
      chk($sformatf("v%0d i_ready", k), {31'b0, bus.in_i_tready}, {31'b0, v[k].e_i_ready});
      chk($sformatf("v%0d q_ready", k), {31'b0, bus.in_q_tready}, {31'b0, v[k].e_q_ready});
      chk($sformatf("v%0d o_valid", k), {31'b0, bus.out_tvalid}, {31'b0, v[k].e_o_valid});
      chk($sformatf("v%0d o_i", k), {16'b0, bus.out_i_tdata}, {16'b0, v[k].e_o_i});
      chk($sformatf("v%0d o_q", k), {16'b0, bus.out_q_tdata}, {16'b0, v[k].e_o_q});
    end
    drive(0, 16'h0000, 0, 16'h0000, 0, 1);
    beats = 0;
    for (int n = 0; n < 10; n++) begin
      if (n < 8) drive(1, 16'(n), 1, 16'(16'h0100 + n), 1, 1);
      else       drive(1, 16'h0000, 0, 16'h0000, 0, 1);
      chk($sformatf("s%0d i_ready", n), {31'b0, bus.in_i_tready}, 32'd1);
      chk($sformatf("s%0d q_ready", n), {31'b0, bus.in_q_tready}, 32'd1);
      chk($sformatf("s%0d o_valid", n), {31'b0, bus.out_tvalid}, (n >= 1 && n <= 8) ? 32'd1 : 32'd0);
      if (n >= 1 && n <= 8) begin
        chk($sformatf("s%0d o_i", n), {16'b0, bus.out_i_tdata}, 32'(n - 1));
        chk($sformatf("s%0d o_q", n), {16'b0, bus.out_q_tdata}, 32'(16'h0100 + n - 1));
      end
      if (bus.out_tvalid && bus.out_tready) beats++;
    end
    chk("stream beats", 32'(beats), 32'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
